// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the instruction-fetch and data ports.
// DM wins ties unless IF has been passed over STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] LAT_C    = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_r, next_state_s;
  logic [3:0]        lat_cnt_r, lat_cnt_s;
  logic [3:0]        starve_cnt_r, starve_cnt_s;
  logic              win_dm_r, win_dm_s;
  logic              win_we_r, win_we_s;
  logic              dm_win_s;
  logic              mem_en_r, mem_en_s;
  logic              mem_we_r, mem_we_s;
  logic [BE_W-1:0]   mem_be_r, mem_be_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
  logic              if_ready_r, if_ready_s;
  logic [DATA_W-1:0] dm_rdata_r, dm_rdata_s;
  logic              dm_ready_r, dm_ready_s;
  logic              busy_r, busy_s;

  // Next-state, arbitration and next values for every output register.
  always_comb begin
    next_state_s = state_r;
    lat_cnt_s    = lat_cnt_r;
    starve_cnt_s = starve_cnt_r;
    win_dm_s     = win_dm_r;
    win_we_s     = win_we_r;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_be_s     = '0;
    mem_addr_s   = '0;
    mem_wdata_s  = '0;
    if_rdata_s   = if_rdata_r;
    if_ready_s   = 1'b0;
    dm_rdata_s   = dm_rdata_r;
    dm_ready_s   = 1'b0;
    // IF is forced only when it is actually waiting and has been starved out.
    dm_win_s     = dm_req && !(if_req && (starve_cnt_r == STARVE_C));

    case (state_r)
      ST_IDLE: begin
        if (dm_win_s) begin
          next_state_s = ST_ISSUE;
          win_dm_s     = 1'b1;
          win_we_s     = dm_we;
          mem_en_s     = 1'b1;
          mem_we_s     = dm_we;
          mem_be_s     = dm_we ? dm_be : {BE_W{1'b1}};
          mem_addr_s   = dm_addr;
          mem_wdata_s  = dm_we ? dm_wdata : {DATA_W{1'b0}};
          if (if_req) begin
            starve_cnt_s = (starve_cnt_r == STARVE_C) ? starve_cnt_r : starve_cnt_r + 4'd1;
          end else begin
            starve_cnt_s = 4'd0;
          end
        end else if (if_req) begin
          next_state_s = ST_ISSUE;
          win_dm_s     = 1'b0;
          win_we_s     = 1'b0;
          mem_en_s     = 1'b1;
          mem_we_s     = 1'b0;
          mem_be_s     = {BE_W{1'b1}};
          mem_addr_s   = if_addr;
          mem_wdata_s  = '0;
          starve_cnt_s = 4'd0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        lat_cnt_s    = LAT_C;
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        lat_cnt_s = lat_cnt_r - 4'd1;
        if (lat_cnt_r <= 4'd1) begin
          next_state_s = ST_RESP;
          if (win_dm_r) begin
            dm_rdata_s = win_we_r ? {DATA_W{1'b0}} : mem_rdata;
            dm_ready_s = 1'b1;
          end else begin
            if_rdata_s = mem_rdata;
            if_ready_s = 1'b1;
          end
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    busy_s = (next_state_s != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Control, bookkeeping and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_r    <= 4'd0;
      starve_cnt_r <= 4'd0;
      win_dm_r     <= 1'b0;
      win_we_r     <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= '0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      if_rdata_r   <= '0;
      if_ready_r   <= 1'b0;
      dm_rdata_r   <= '0;
      dm_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      lat_cnt_r    <= lat_cnt_s;
      starve_cnt_r <= starve_cnt_s;
      win_dm_r     <= win_dm_s;
      win_we_r     <= win_we_s;
      mem_en_r     <= mem_en_s;
      mem_we_r     <= mem_we_s;
      mem_be_r     <= mem_be_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      if_rdata_r   <= if_rdata_s;
      if_ready_r   <= if_ready_s;
      dm_rdata_r   <= dm_rdata_s;
      dm_ready_r   <= dm_ready_s;
      busy_r       <= busy_s;
    end
  end

  assign if_rdata  = if_rdata_r;
  assign if_ready  = if_ready_r;
  assign dm_rdata  = dm_rdata_r;
  assign dm_ready  = dm_ready_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_be    = mem_be_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// each with a memory model that presents read data only in its exact valid cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = 4'h0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;

  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_ready, a_dm_ready, a_mem_en, a_mem_we, a_busy;
  logic [3:0]  a_mem_be;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_busy;
  logic [3:0]  b_mem_be;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ready(a_dm_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_val = 32'h0000_0013;
      32'h0000_2000: mem_val = 32'hCAFE_0001;
      default:       mem_val = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory models: data is valid only in the cycle MEM_LAT after the command, garbage otherwise.
  logic [3:0]  a_cnt = 4'd0, b_cnt = 4'd0;
  logic [31:0] a_q = 32'h0, b_q = 32'h0;
  always @(posedge clk) begin
    if (a_mem_en) begin a_cnt <= 4'd1; a_q <= a_mem_addr; end
    else if (a_cnt != 4'd0) a_cnt <= a_cnt - 4'd1;
    if (b_mem_en) begin b_cnt <= 4'd3; b_q <= b_mem_addr; end
    else if (b_cnt != 4'd0) b_cnt <= b_cnt - 4'd1;
  end
  assign a_mem_rdata = (a_cnt == 4'd1) ? mem_val(a_q) : 32'hBAD0_BAD0;
  assign b_mem_rdata = (b_cnt == 4'd1) ? mem_val(b_q) : 32'hBAD0_BAD0;

  // Observed vector: {mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_ready, if_rdata, dm_ready, dm_rdata, busy}
  logic [136:0] a_obs, b_obs;
  assign a_obs = {a_mem_en, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata, a_if_ready, a_if_rdata, a_dm_ready, a_dm_rdata, a_busy};
  assign b_obs = {b_mem_en, b_mem_we, b_mem_be, b_mem_addr, b_mem_wdata, b_if_ready, b_if_rdata, b_dm_ready, b_dm_rdata, b_busy};

  typedef struct {
    logic         if_req;
    logic [31:0]  if_addr;
    logic         dm_req;
    logic         dm_we;
    logic [3:0]   dm_be;
    logic [31:0]  dm_addr;
    logic [31:0]  dm_wdata;
    logic [136:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd,
                              input logic en, input logic we, input logic [3:0] be, input logic [31:0] ma,
                              input logic [31:0] md, input logic irdy, input logic [31:0] ird,
                              input logic drdy, input logic [31:0] drd, input logic bsy);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
    v.dm_be = db; v.dm_addr = da; v.dm_wdata = dd;
    v.exp = {en, we, be, ma, md, irdy, ird, drdy, drd, bsy};
    return v;
  endfunction

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk1(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
    dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants[$];
    int exp_grant[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int en1, en2, rdy1;
    logic [31:0] rd1;

    // MEM_LAT=1 cycle-by-cycle table: single IF read, simultaneous IF/DM read, DM partial write.
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 4'hF, 32'h100,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 32'h13,       1'b0, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h13,       1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h104, 1'b1, 1'b0, 4'h0, 32'h2000, 32'h55555555, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h13,       1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 32'h104, 1'b1, 1'b0, 4'h0, 32'h2000, 32'h55555555, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0,        1'b0, 32'h13,       1'b0, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'h104, 1'b1, 1'b0, 4'h0, 32'h2000, 32'h55555555, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h13,       1'b0, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h13,       1'b1, 32'hCAFE0001, 1'b1));
    vecs.push_back(mk(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h13,       1'b0, 32'hCAFE0001, 1'b0));
    vecs.push_back(mk(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 1'b0, 4'hF, 32'h104,  32'h0,        1'b0, 32'h13,       1'b0, 32'hCAFE0001, 1'b1));
    vecs.push_back(mk(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h13,       1'b0, 32'hCAFE0001, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 32'hA5A50104, 1'b0, 32'hCAFE0001, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'hA5A50104, 1'b0, 32'hCAFE0001, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 4'h3, 32'h2004, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'hA5A50104, 1'b0, 32'hCAFE0001, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 4'h3, 32'h2004, 32'hDEADBEEF, 1'b1, 1'b1, 4'h3, 32'h2004, 32'hDEADBEEF, 1'b0, 32'hA5A50104, 1'b0, 32'hCAFE0001, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,   1'b1, 1'b1, 4'h3, 32'h2004, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'hA5A50104, 1'b0, 32'hCAFE0001, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'hA5A50104, 1'b1, 32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'hA5A50104, 1'b0, 32'h0,        1'b0));

    // Reset state of both instances.
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", a_obs, 137'h0);
    chk("reset_b", b_obs, 137'h0);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_be = vecs[i].dm_be;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      @(negedge clk);
      chk($sformatf("vec%0d", i + 1), a_obs, vecs[i].exp);
    end

    // Starvation: both held continuously; IF must get every fifth grant.
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2100;
    for (int c = 0; c < 80 && grants.size() < 11; c++) begin
      @(negedge clk);
      if (a_mem_en) grants.push_back((a_mem_addr == 32'h300) ? 1 : 0);
    end
    chk1("starve_grant_count", grants.size(), 11);
    for (int g = 0; g < 11; g++) begin
      if (g < grants.size()) chk1($sformatf("starve_grant%0d_is_if", g + 1), grants[g], exp_grant[g]);
    end

    // Reset during WAIT at MEM_LAT=3: outputs clear at once, no ready afterwards.
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_busy_b", {136'h0, b_busy}, 137'h1);
    rst = 1'b1;
    drive_idle();
    #1;
    chk("rst_async_clear_b", b_obs, 137'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rst_after_c%0d", c), b_obs, 137'h0);
    end

    // Back-to-back IF reads at MEM_LAT=3 with if_req held through ready.
    do_reset();
    en1 = 0; en2 = 0; rdy1 = 0; rd1 = 32'h0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h180;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (b_mem_en && en1 == 0) en1 = c;
      else if (b_mem_en && en2 == 0) en2 = c;
      if (b_if_ready && rdy1 == 0) begin rdy1 = c; rd1 = b_if_rdata; end
      @(posedge clk); #1;
    end
    drive_idle();
    chk1("b2b_first_mem_en_cycle", en1, 2);
    chk1("b2b_second_mem_en_cycle", en2, 8);
    chk1("b2b_first_ready_cycle", rdy1, 6);
    chk("b2b_first_rdata", {105'h0, rd1}, {105'h0, 32'hA5A50180});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
